// File: rtl/rx_frame_packer_if.sv
// rx_frame_packer_if
// Groups the two streams of the frame packer:
//   rx_tdata/rx_tvalid  : per-channel decimated I/Q samples (no ready, never stalled)
//   out_t*              : packed frame stream with valid/ready handshake
// Modports:
//   master : the environment (drives samples and out_tready)
//   slave  : the packer itself
interface rx_frame_packer_if #(
    parameter int NR = 6,
    parameter int SW = 24
);
    logic [NR*2*SW-1:0] rx_tdata;
    logic [NR-1:0]      rx_tvalid;
    logic [2*SW-1:0]    out_tdata;
    logic [3:0]         out_tuser;
    logic               out_tlast;
    logic               out_tvalid;
    logic               out_tready;

    modport master (
        output rx_tdata, rx_tvalid, out_tready,
        input  out_tdata, out_tuser, out_tlast, out_tvalid
    );

    modport slave (
        input  rx_tdata, rx_tvalid, out_tready,
        output out_tdata, out_tuser, out_tlast, out_tvalid
    );
endinterface

// File: rtl/rx_frame_packer.sv
// rx_frame_packer
// Collects one I/Q sample per active receiver channel into holding registers
// and, once every active channel holds a sample, emits them as one frame on a
// valid/ready stream in channel order. Samples arriving on a channel that is
// still full are dropped and counted as overruns.
// Ports:
//   clk        : sample-domain clock
//   rst        : synchronous active-high reset
//   bus        : rx sample inputs and packed output stream (slave modport)
//   active_nr  : channels to pack (0 means 1, values above NR mean NR)
//   ovf_clr    : clears overrun flags and counter
//   ovf_flags  : sticky per-channel overrun flags
//   ovf_cnt    : saturating count of dropped samples
module rx_frame_packer #(
    parameter int NR = 6,
    parameter int SW = 24
) (
    input  logic             clk,
    input  logic             rst,
    rx_frame_packer_if.slave bus,
    input  logic [3:0]       active_nr,
    input  logic             ovf_clr,
    output logic [NR-1:0]    ovf_flags,
    output logic [15:0]      ovf_cnt
);
    localparam int DW = 2 * SW;
    localparam logic [3:0] NR4 = 4'(NR);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t        r_state;
    state_t        w_nextState;

    logic [DW-1:0] r_hold [NR];
    logic [NR-1:0] r_full;
    logic [3:0]    r_idx;
    logic [3:0]    r_nrLat;
    logic [NR-1:0] r_ovfFlags;
    logic [15:0]   r_ovfCnt;

    logic [3:0]    w_effNr;
    logic [NR-1:0] w_active;
    logic [NR-1:0] w_xferVec;
    logic [NR-1:0] w_capture;
    logic [NR-1:0] w_overrun;
    logic [4:0]    w_ovfNum;
    logic [16:0]   w_ovfSum;
    logic [DW-1:0] w_sendWord;
    logic          w_xfer;
    logic          w_last;
    logic          w_allFull;
    logic          w_sending;

    // Effective channel count: zero is promoted to one, oversize is clamped.
    always_comb begin
        w_effNr = active_nr;
        if (active_nr == 4'd0) begin
            w_effNr = 4'd1;
        end else if (active_nr > NR4) begin
            w_effNr = NR4;
        end
    end

    assign w_sending = (r_state == S_SEND);
    assign w_xfer    = w_sending && bus.out_tready;
    assign w_last    = (r_idx == r_nrLat - 4'd1);
    // Inactive channels count as satisfied so only active ones gate the frame.
    assign w_allFull = &(r_full | ~w_active);

    // A full channel may still capture when its word leaves in the same cycle.
    always_comb begin
        w_active   = '0;
        w_xferVec  = '0;
        w_capture  = '0;
        w_overrun  = '0;
        w_ovfNum   = '0;
        w_sendWord = '0;
        for (int k = 0; k < NR; k++) begin
            w_active[k]  = (4'(k) < w_effNr);
            w_xferVec[k] = w_xfer && (r_idx == 4'(k));
            w_capture[k] = w_active[k] && bus.rx_tvalid[k] && (!r_full[k] || w_xferVec[k]);
            w_overrun[k] = w_active[k] && bus.rx_tvalid[k] && r_full[k] && !w_xferVec[k];
            w_ovfNum     = w_ovfNum + {4'd0, w_overrun[k]};
            if (r_idx == 4'(k)) begin
                w_sendWord = r_hold[k];
            end
        end
    end

    assign w_ovfSum = {1'b0, r_ovfCnt} + {12'd0, w_ovfNum};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_allFull) w_nextState = S_SEND;
            S_SEND:  if (w_xfer && w_last) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // The channel count is latched only when a frame starts, so a run-time
    // change of active_nr never truncates or extends a frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= 4'd0;
            r_nrLat <= 4'd1;
        end else if (r_state == S_IDLE) begin
            if (w_allFull) begin
                r_idx   <= 4'd0;
                r_nrLat <= w_effNr;
            end
        end else if (w_xfer) begin
            r_idx <= r_idx + 4'd1;
        end
    end

    // Inactive channels are forced empty; their held data stays in place so a
    // frame already latched with a larger count still emits correct words.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= '0;
            for (int k = 0; k < NR; k++) begin
                r_hold[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NR; k++) begin
                if (w_capture[k]) begin
                    r_hold[k] <= bus.rx_tdata[k*DW +: DW];
                    r_full[k] <= 1'b1;
                end else if (w_xferVec[k] || !w_active[k]) begin
                    r_full[k] <= 1'b0;
                end
            end
        end
    end

    // Clear wins over a simultaneous overrun; the count saturates at 0xFFFF.
    always_ff @(posedge clk) begin
        if (rst || ovf_clr) begin
            r_ovfFlags <= '0;
            r_ovfCnt   <= '0;
        end else begin
            r_ovfFlags <= r_ovfFlags | w_overrun;
            r_ovfCnt   <= w_ovfSum[16] ? 16'hFFFF : w_ovfSum[15:0];
        end
    end

    assign bus.out_tvalid = w_sending;
    assign bus.out_tdata  = w_sending ? w_sendWord : '0;
    assign bus.out_tuser  = w_sending ? r_idx : 4'd0;
    assign bus.out_tlast  = w_sending && w_last;
    assign ovf_flags      = r_ovfFlags;
    assign ovf_cnt        = r_ovfCnt;
endmodule

// File: tb/tb_rx_frame_packer.sv
// tb_rx_frame_packer
// Drives rx_frame_packer (NR=6, SW=24) with random and directed sample
// patterns and compares the packed output stream and overrun accounting
// against a frame-level model of held samples and drop counts.
`timescale 1ns/1ps
module tb_rx_frame_packer;
    localparam int NR = 6;
    localparam int SW = 24;
    localparam int DW = 2 * SW;

    typedef struct packed {
        logic [3:0]    user;
        logic          last;
        logic [DW-1:0] data;
    } word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    activeNr;
    logic          ovfClr;
    logic [NR-1:0] ovfFlags;
    logic [15:0]   ovfCnt;

    int errors = 0;
    int checks = 0;

    // Reference model: what each channel holds, whether it is occupied, and
    // the expected overrun state.
    logic [DW-1:0] mHold [NR];
    logic [NR-1:0] mFull;
    logic [NR-1:0] mFlags;
    int            mCnt;

    logic [DW-1:0] stimWords [NR];
    word_t         obsQ [$];
    logic [3:0]    activeTable [6] = '{4'd3, 4'd0, 4'd15, 4'd1, 4'd6, 4'd4};

    rx_frame_packer_if #(.NR(NR), .SW(SW)) bus ();

    rx_frame_packer #(.NR(NR), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .active_nr (activeNr),
        .ovf_clr   (ovfClr),
        .ovf_flags (ovfFlags),
        .ovf_cnt   (ovfCnt)
    );

    always #5 clk = ~clk;

    // Record every word that is accepted by the downstream side.
    always @(negedge clk) begin
        if (!rst && bus.out_tvalid && bus.out_tready) begin
            obsQ.push_back({bus.out_tuser, bus.out_tlast, bus.out_tdata});
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int effOf(input logic [3:0] a);
        if (a == 4'd0) return 1;
        if (int'(a) > NR) return NR;
        return int'(a);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic randomizeWords();
        logic [63:0] r;
        for (int k = 0; k < NR; k++) begin
            r = {$urandom(), $urandom()};
            stimWords[k] = r[DW-1:0];
        end
    endtask

    // One strobe cycle; the model assumes no word leaves during this cycle.
    task automatic applyStimulus(input logic [NR-1:0] mask);
        int eff;
        int nOv;
        eff = effOf(activeNr);
        nOv = 0;
        for (int k = 0; k < NR; k++) begin
            bus.rx_tdata[k*DW +: DW] = stimWords[k];
        end
        bus.rx_tvalid = mask;
        @(posedge clk);
        #1;
        bus.rx_tvalid = '0;
        for (int k = 0; k < eff; k++) begin
            if (mask[k]) begin
                if (!mFull[k]) begin
                    mHold[k] = stimWords[k];
                    mFull[k] = 1'b1;
                end else begin
                    mFlags[k] = 1'b1;
                    nOv++;
                end
            end
        end
        mCnt = (mCnt + nOv > 65535) ? 65535 : mCnt + nOv;
    endtask

    task automatic expectFrame(input int n);
        word_t w;
        int    waited;
        waited = 0;
        while (obsQ.size() < n && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        #1;
        checkOutput("frameArrived", 64'(obsQ.size() >= n), 64'd1);
        for (int i = 0; i < n; i++) begin
            if (obsQ.size() > 0) begin
                w = obsQ.pop_front();
                checkOutput($sformatf("word%0dUser", i), 64'(w.user), 64'(i));
                checkOutput($sformatf("word%0dData", i), 64'(w.data), 64'(mHold[i]));
                checkOutput($sformatf("word%0dLast", i), 64'(w.last), 64'(i == n - 1));
            end
        end
        for (int i = 0; i < n; i++) begin
            mFull[i] = 1'b0;
        end
    endtask

    task automatic waitForWord(input logic [3:0] user);
        int waited;
        waited = 0;
        while (!(bus.out_tvalid && bus.out_tuser == user) && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput($sformatf("waitWord%0d", user), 64'({bus.out_tvalid, bus.out_tuser}), 64'({1'b1, user}));
    endtask

    initial begin
        logic [DW-1:0] refillWord;
        logic [63:0]   r;

        rst            = 1'b1;
        activeNr       = 4'd6;
        ovfClr         = 1'b0;
        bus.rx_tdata   = '0;
        bus.rx_tvalid  = '0;
        bus.out_tready = 1'b1;
        mFull          = '0;
        mFlags         = '0;
        mCnt           = 0;
        for (int k = 0; k < NR; k++) mHold[k] = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetValid", 64'(bus.out_tvalid), 64'd0);
        checkOutput("resetLast", 64'(bus.out_tlast), 64'd0);
        checkOutput("resetData", 64'(bus.out_tdata), 64'd0);
        checkOutput("resetUser", 64'(bus.out_tuser), 64'd0);
        checkOutput("resetFlags", 64'(ovfFlags), 64'd0);
        checkOutput("resetCnt", 64'(ovfCnt), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic frame with recognisable data and two-cycle latency.
        for (int k = 0; k < NR; k++) stimWords[k] = {24'(k + 1), 24'(256 + k)};
        applyStimulus('1);
        checkOutput("latencyEdgeE", 64'(bus.out_tvalid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("latencyEdgeE1", 64'(bus.out_tvalid), 64'd1);
        checkOutput("firstUser", 64'(bus.out_tuser), 64'd0);
        expectFrame(6);
        checkOutput("basicOvfCnt", 64'(ovfCnt), 64'd0);

        // Strobes on channels beyond the active count must not start a frame.
        activeNr = 4'd3;
        randomizeWords();
        applyStimulus(6'b111000);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("inactiveNoValid", 64'(bus.out_tvalid), 64'd0);
        checkOutput("inactiveNoWords", 64'(obsQ.size()), 64'd0);

        // Random data under several channel counts, including 0 and 15.
        for (int rnd = 0; rnd < 6; rnd++) begin
            activeNr = activeTable[rnd];
            randomizeWords();
            applyStimulus('1);
            expectFrame(effOf(activeNr));
            repeat (3) @(posedge clk);
            #1;
            checkOutput("roundExtraWords", 64'(obsQ.size()), 64'd0);
            checkOutput("roundOvfCnt", 64'(ovfCnt), 64'(mCnt));
        end

        // Back-pressure with repeated strobes on channel 2.
        activeNr       = 4'd6;
        bus.out_tready = 1'b0;
        randomizeWords();
        applyStimulus('1);
        for (int j = 0; j < 3; j++) begin
            randomizeWords();
            repeat (4) @(posedge clk);
            #1;
            applyStimulus(6'b000100);
        end
        checkOutput("bpDataEarly", 64'(bus.out_tdata), 64'(mHold[0]));
        repeat (8) @(posedge clk);
        #1;
        checkOutput("bpValid", 64'(bus.out_tvalid), 64'd1);
        checkOutput("bpUser", 64'(bus.out_tuser), 64'd0);
        checkOutput("bpDataLate", 64'(bus.out_tdata), 64'(mHold[0]));
        checkOutput("bpLast", 64'(bus.out_tlast), 64'd0);
        checkOutput("ovfFlags", 64'(ovfFlags), 64'(mFlags));
        checkOutput("ovfCnt", 64'(ovfCnt), 64'(mCnt));
        bus.out_tready = 1'b1;
        expectFrame(6);
        ovfClr = 1'b1;
        @(posedge clk);
        #1;
        ovfClr = 1'b0;
        mFlags = '0;
        mCnt   = 0;
        checkOutput("clrFlags", 64'(ovfFlags), 64'(mFlags));
        checkOutput("clrCnt", 64'(ovfCnt), 64'(mCnt));

        // Channel 0 refills in the very cycle its word is accepted.
        randomizeWords();
        applyStimulus('1);
        waitForWord(4'd0);
        r = {$urandom(), $urandom()};
        refillWord = r[DW-1:0];
        bus.rx_tdata[0 +: DW] = refillWord;
        bus.rx_tvalid = 6'b000001;
        @(posedge clk);
        #1;
        bus.rx_tvalid = '0;
        expectFrame(6);
        mHold[0] = refillWord;
        mFull[0] = 1'b1;
        checkOutput("refillOvfCnt", 64'(ovfCnt), 64'd0);
        checkOutput("refillOvfFlags", 64'(ovfFlags), 64'd0);
        randomizeWords();
        applyStimulus(6'b111110);
        expectFrame(6);

        // Channel count change during a frame applies from the next frame.
        randomizeWords();
        applyStimulus('1);
        waitForWord(4'd0);
        activeNr = 4'd2;
        expectFrame(6);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("changeExtraWords", 64'(obsQ.size()), 64'd0);
        randomizeWords();
        applyStimulus('1);
        expectFrame(2);

        // Reset while word 3 is on the bus.
        activeNr = 4'd6;
        randomizeWords();
        applyStimulus('1);
        waitForWord(4'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstValidNext", 64'(bus.out_tvalid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        obsQ.delete();
        mFull  = '0;
        mFlags = '0;
        mCnt   = 0;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("postRstWords", 64'(obsQ.size()), 64'd0);
        checkOutput("postRstValid", 64'(bus.out_tvalid), 64'd0);
        randomizeWords();
        applyStimulus('1);
        expectFrame(6);

        // Saturation: 65540 drops with the frame held back.
        bus.out_tready = 1'b0;
        randomizeWords();
        applyStimulus('1);
        for (int j = 0; j < 10923; j++) applyStimulus('1);
        applyStimulus(6'b000011);
        checkOutput("satCnt", 64'(ovfCnt), 64'(mCnt));
        checkOutput("satFlags", 64'(ovfFlags), 64'(mFlags));

        // Clear beats a simultaneous overrun.
        ovfClr = 1'b1;
        applyStimulus('1);
        ovfClr = 1'b0;
        mFlags = '0;
        mCnt   = 0;
        checkOutput("clrPriorityCnt", 64'(ovfCnt), 64'(mCnt));
        checkOutput("clrPriorityFlags", 64'(ovfFlags), 64'(mFlags));

        // Four simultaneous drops starting from 0xFFFD.
        for (int j = 0; j < 10922; j++) applyStimulus('1);
        applyStimulus(6'b000001);
        checkOutput("cntFFFD", 64'(ovfCnt), 64'(mCnt));
        applyStimulus(6'b001111);
        checkOutput("sat4Chan", 64'(ovfCnt), 64'(mCnt));

        bus.out_tready = 1'b1;
        expectFrame(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rx_frame_packer.md
# rx_frame_packer

Parametrised receive-sample frame packer sitting between the NR-channel DDC/decimator bank and the Ethernet RX-data framing logic of the core. Each receiver drops one 48-bit I/Q sample per decimated output strobe into a per-channel holding register. Once every active channel holds a sample, the block emits one frame of `active_nr` words on a single valid/ready stream, in channel order. It generalises the fixed six-receiver arrangement to up to 12 channels, adds a run-time channel count, back-pressure, and per-channel overrun accounting.

## Interface

Parameters:
- `NR`, 6: number of physical receiver channels, 1..12.
- `SW`, 24: width of I and of Q; a sample word is 2*SW bits, I in the upper half.

Ports:
- `clk`  in  1: the single clock, receiver sample domain.
- `rst`  in  1: synchronous reset, active-high.
- `rx_tdata`  in  NR*2*SW: channel k's sample is at bits [k*2*SW +: 2*SW].
- `rx_tvalid`  in  NR: one-cycle strobe per channel; there is no ready signal, so samples are never stalled.
- `active_nr`  in  4: number of channels to pack. 0 is treated as 1; values above NR are clamped to NR.
- `out_tdata`  out  2*SW: sample word.
- `out_tuser`  out  4: channel index of `out_tdata`.
- `out_tlast`  out  1: marks the last word of a frame.
- `out_tvalid`  out  1: output valid.
- `out_tready`  in  1: downstream ready.
- `ovf_clr`  in  1: clears `ovf_flags` and `ovf_cnt`.
- `ovf_flags`  out  NR: sticky per-channel overrun flags.
- `ovf_cnt`  out  16: saturating total count of dropped samples.

## Operation

- Each channel k has a holding register `hold[k]` and a full bit `full[k]`.
- On `rx_tvalid[k]` with `full[k]`=0, or with `hold[k]` being transferred out in the same cycle, the register captures `rx_tdata[k]` and `full[k]` is set to 1.
- Overrun: `rx_tvalid[k]` with `full[k]`=1 and no transfer of channel k in that cycle.
  - The new sample is dropped and the old sample is kept.
  - `ovf_flags[k]` is set.
  - `ovf_cnt` increments and saturates at 0xFFFF.
  - If several channels overrun in one cycle, `ovf_cnt` adds the number of overrunning channels, still saturating.
- Channels with index ≥ effective `active_nr`:
  - `rx_tvalid` is ignored, `full` is held at 0, and no overrun is counted.
  - Channel indices ≥ NR do not exist.
- State machine, IDLE/SEND:
  - IDLE: when `full[k]`=1 for every k < effective `active_nr`, latch the effective count into `nr_lat`, set `idx`=0, and go to SEND. `active_nr` is sampled only here, so a change mid-frame takes effect on the next frame.
  - SEND: `out_tvalid`=1, `out_tdata`=`hold[idx]`, `out_tuser`=`idx`, `out_tlast`=(`idx`==`nr_lat`-1).
  - On `out_tvalid && out_tready`: clear `full[idx]` (unless refilled in the same cycle), then `idx`+1. If `out_tlast`, return to IDLE.
- A channel already emitted may refill during SEND. That sample belongs to the next frame.
- `ovf_clr` has priority over an overrun occurring in the same cycle: flags and counter go to 0.

## Timing

- Reset values:
  - outputs: `out_tvalid`=0, `out_tlast`=0, `out_tdata`=0, `out_tuser`=0, `ovf_flags`=0, `ovf_cnt`=0.
  - internal: state IDLE, all `full`=0.
- Reset mid-frame discards every held sample and the partial frame. `out_tvalid` is 0 in the cycle after reset is asserted.
- Latency: the last required `rx_tvalid` is sampled at edge E. `out_tvalid` rises after edge E+1, i.e. two cycles.
- `out_tdata`, `out_tuser` and `out_tlast` are stable while `out_tvalid`=1 and `out_tready`=0.
- Throughput: one word per cycle with `out_tready` held at 1. A frame of n words therefore occupies n cycles.
- IDLE→SEND costs one cycle per frame. Back-to-back frames leave a one-cycle `out_tvalid` gap.
- All outputs are registered or decoded from registered state only. There is no combinational path from `out_tready` to `out_tvalid`.

## Test plan

- Basic frame:
  - NR=6, `active_nr`=6, `out_tready`=1; strobe all channels with `rx_tdata[k]`={I=k+1, Q=0x100+k}.
  - Expect 6 words, `out_tuser` 0..5, `out_tlast` only on index 5, first `out_tvalid` two cycles after the strobe, `ovf_cnt`=0.
- Partial channel count and clamping:
  - `active_nr`=3: frames of 3 words, `out_tlast` at index 2; strobes on channels 3..5 are ignored.
  - `active_nr`=0: 1-word frames.
  - `active_nr`=15 with NR=6: 6-word frames.
- Back-pressure and overrun:
  - Hold `out_tready`=0 for 20 cycles with a frame pending.
  - Strobe channel 2 three more times. Expect `ovf_flags`=6'b000100, `ovf_cnt`=3, and the frame still carries the first channel-2 sample.
  - Assert `ovf_clr` and expect both to return to 0.
- Same-cycle transfer and refill:
  - Strobe channel 0 in the cycle its word transfers.
  - Expect no overrun; the next frame carries the new channel-0 sample.
- Runtime change and reset:
  - Change `active_nr` 6→2 mid-SEND: the current frame completes with 6 words, and the next frame has 2 words.
  - Assert `rst` at word 3: `out_tvalid`=0 the next cycle, and no stale word appears after reset releases.
- Saturation:
  - Force 65 540 overruns. `ovf_cnt` stops at 0xFFFF.
  - A simultaneous overrun on 4 channels starting from 0xFFFD gives 0xFFFF.
